// File: rtl/rsp_s2_dma_axi_rdata.sv
// AXI R-channel beat counter for the RSP S2 DMA read path: matches R beats against
// burst lengths from the ALEN FIFO, forwards data and tags burst-final beats with end flags.
module rsp_s2_dma_axi_rdata #(
    parameter int DATA_WIDTH = 128,
    parameter int ALEN_INFO  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    update,
    input  logic                    alen_fifo_empty,
    input  logic [ALEN_INFO+7:0]    alen_fifo_dout,
    output logic                    alen_fifo_pop,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [DATA_WIDTH-1:0]   dout_data,
    output logic [3:0]              dout_flags,
    output logic                    done,
    output logic                    err_len,
    output logic                    err_resp
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0] state;
    logic       loaded;
    logic [7:0] beat_cnt;
    logic [7:0] cur_alen;
    logic [3:0] cur_flags;
    logic       beat_fire;
    logic       is_last;

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // a valid source holds its payload stable until that edge.
    assign rready        = ~update & (state == BURST) & loaded & (~dout_valid | dout_ready);
    assign beat_fire     = rvalid & rready;
    assign is_last       = (beat_cnt == cur_alen);
    assign alen_fifo_pop = beat_fire & is_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            loaded    <= 1'b0;
            beat_cnt  <= 8'd0;
            cur_alen  <= 8'd0;
            cur_flags <= 4'd0;
        end else if (update) begin
            state    <= IDLE;
            loaded   <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!alen_fifo_empty) begin
                        cur_alen  <= alen_fifo_dout[7:0];
                        cur_flags <= alen_fifo_dout[8 +: 4];
                        loaded    <= 1'b1;
                        state     <= BURST;
                    end
                end
                default: begin
                    if (loaded) begin
                        if (beat_fire) begin
                            if (is_last) begin
                                beat_cnt <= 8'd0;
                                loaded   <= 1'b0;
                            end else begin
                                beat_cnt <= beat_cnt + 8'd1;
                            end
                        end
                    end else if (!alen_fifo_empty) begin
                        // Bubble cycle after a pop: the FWFT head now shows the next entry.
                        cur_alen  <= alen_fifo_dout[7:0];
                        cur_flags <= alen_fifo_dout[8 +: 4];
                        loaded    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_flags <= 4'd0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            err_resp   <= 1'b0;
        end else if (update) begin
            dout_valid <= 1'b0;
            dout_flags <= 4'd0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            err_resp   <= 1'b0;
        end else begin
            done <= dout_valid & dout_ready & dout_flags[0];
            if (beat_fire) begin
                dout_valid <= 1'b1;
                dout_data  <= rdata;
                dout_flags <= is_last ? cur_flags : 4'd0;
                if (rlast != is_last) begin
                    err_len <= 1'b1;
                end
                if (rresp != 2'b00) begin
                    err_resp <= 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
                dout_flags <= 4'd0;
            end
        end
    end

endmodule
